// File: rtl/stall_ctrl_if.sv
// Pipeline-to-hazard-unit bundle: D/E/M dependency info in, stall controls and debug counter out.
interface stall_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       D_rs;
  logic [4:0]       D_rt;
  logic [1:0]       D_Tuse_rs;
  logic [1:0]       D_Tuse_rt;
  logic             D_is_md;
  logic [4:0]       E_wa;
  logic [1:0]       E_Tnew;
  logic [4:0]       M_wa;
  logic [1:0]       M_Tnew;
  logic             E_start;
  logic             E_md_div;
  logic             F_enable;
  logic             D_enable;
  logic             E_clear;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cnt;

  // Pipeline side
  modport master (
    output D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_is_md,
    output E_wa, E_Tnew, M_wa, M_Tnew, E_start, E_md_div,
    input  F_enable, D_enable, E_clear, md_busy, stall_cnt
  );

  // Hazard controller side
  modport slave (
    input  D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_is_md,
    input  E_wa, E_Tnew, M_wa, M_Tnew, E_start, E_md_div,
    output F_enable, D_enable, E_clear, md_busy, stall_cnt
  );
endinterface

// File: rtl/stall_ctrl.sv
// Hazard/stall controller: Tuse/Tnew dependency stalls, MDU busy tracking and a
// saturating stall-cycle counter.
module stall_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10,
  parameter int unsigned CNT_W    = 32
) (
  input logic         clk,
  input logic         reset,
  stall_ctrl_if.slave bus
);

  localparam int unsigned MaxCyc = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int unsigned MdW    = ($clog2(MaxCyc + 1) > 4) ? $clog2(MaxCyc + 1) : 4;

  logic [MdW-1:0]   r_md_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_md_busy;
  logic             w_stall_rs;
  logic             w_stall_rt;
  logic             w_stall_md;
  logic             w_stall;

  assign w_md_busy = (r_md_cnt != '0);

  // Register 0 is hard-wired, so a match on it is never a real dependency.
  assign w_stall_rs = (bus.D_rs != 5'd0) &&
                      (((bus.D_rs == bus.E_wa) && (bus.E_Tnew > bus.D_Tuse_rs)) ||
                       ((bus.D_rs == bus.M_wa) && (bus.M_Tnew > bus.D_Tuse_rs)));
  assign w_stall_rt = (bus.D_rt != 5'd0) &&
                      (((bus.D_rt == bus.E_wa) && (bus.E_Tnew > bus.D_Tuse_rt)) ||
                       ((bus.D_rt == bus.M_wa) && (bus.M_Tnew > bus.D_Tuse_rt)));

  // E_start counts too, so mult followed directly by mflo stalls in the start cycle.
  assign w_stall_md = bus.D_is_md && (w_md_busy || bus.E_start);
  assign w_stall    = !reset && (w_stall_rs || w_stall_rt || w_stall_md);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_md_cnt <= '0;
    end else if (bus.E_start && !w_md_busy) begin
      r_md_cnt <= bus.E_md_div ? MdW'(DIV_CYC) : MdW'(MULT_CYC);
    end else if (w_md_busy) begin
      r_md_cnt <= r_md_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.F_enable  = !w_stall;
  assign bus.D_enable  = !w_stall;
  assign bus.E_clear   = w_stall;
  assign bus.md_busy   = w_md_busy;
  assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl: a default instance plus a CNT_W=4 copy for saturation.
module tb_stall_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  stall_ctrl_if #(.CNT_W(32)) bus ();
  stall_ctrl_if #(.CNT_W(4))  sbus ();

  assign sbus.D_rs      = bus.D_rs;
  assign sbus.D_rt      = bus.D_rt;
  assign sbus.D_Tuse_rs = bus.D_Tuse_rs;
  assign sbus.D_Tuse_rt = bus.D_Tuse_rt;
  assign sbus.D_is_md   = bus.D_is_md;
  assign sbus.E_wa      = bus.E_wa;
  assign sbus.E_Tnew    = bus.E_Tnew;
  assign sbus.M_wa      = bus.M_wa;
  assign sbus.M_Tnew    = bus.M_Tnew;
  assign sbus.E_start   = bus.E_start;
  assign sbus.E_md_div  = bus.E_md_div;

  stall_ctrl #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  stall_ctrl #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(4)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (sbus)
  );

  // Inputs change on negedge; checks run 1 time unit later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.D_rs = 5'd0; bus.D_rt = 5'd0; bus.D_Tuse_rs = 2'd3; bus.D_Tuse_rt = 2'd3;
    bus.D_is_md = 1'b0; bus.E_wa = 5'd0; bus.E_Tnew = 2'd0; bus.M_wa = 5'd0;
    bus.M_Tnew = 2'd0; bus.E_start = 1'b0; bus.E_md_div = 1'b0;
  endtask

  task automatic do_reset();
    next_cycle();
    idle_inputs();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    bus.D_rs = 5'd5; bus.D_Tuse_rs = 2'd0; bus.E_wa = 5'd5; bus.E_Tnew = 2'd2;
    bus.D_is_md = 1'b1; bus.E_start = 1'b1;
    next_cycle(); #1;
    n_chk++;
    if (bus.F_enable !== 1'b1) $display("FAIL reset_F_enable got=%b exp=1", bus.F_enable);
    else n_pass++;
    n_chk++;
    if (bus.D_enable !== 1'b1) $display("FAIL reset_D_enable got=%b exp=1", bus.D_enable);
    else n_pass++;
    n_chk++;
    if (bus.E_clear !== 1'b0) $display("FAIL reset_E_clear got=%b exp=0", bus.E_clear);
    else n_pass++;
    n_chk++;
    if (bus.md_busy !== 1'b0) $display("FAIL reset_md_busy got=%b exp=0", bus.md_busy);
    else n_pass++;
    n_chk++;
    if (bus.stall_cnt !== 32'd0) $display("FAIL reset_stall_cnt got=%0d exp=0", bus.stall_cnt);
    else n_pass++;
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    bus.D_rs = 5'd5; bus.D_Tuse_rs = 2'd0; bus.E_wa = 5'd5; bus.E_Tnew = 2'd2;
    #1;
    n_chk++;
    if (bus.F_enable !== 1'b0 || bus.D_enable !== 1'b0 || bus.E_clear !== 1'b1)
      $display("FAIL lu_e_stall got F=%b D=%b C=%b exp F=0 D=0 C=1",
               bus.F_enable, bus.D_enable, bus.E_clear);
    else n_pass++;
    next_cycle();
    bus.E_wa = 5'd0; bus.M_wa = 5'd5; bus.M_Tnew = 2'd1;
    #1;
    n_chk++;
    if (bus.E_clear !== 1'b1) $display("FAIL lu_m_stall got=%b exp=1", bus.E_clear);
    else n_pass++;
    n_chk++;
    if (bus.stall_cnt !== 32'd1) $display("FAIL lu_cnt1 got=%0d exp=1", bus.stall_cnt);
    else n_pass++;
    next_cycle();
    bus.M_Tnew = 2'd0;
    #1;
    n_chk++;
    if (bus.E_clear !== 1'b0 || bus.F_enable !== 1'b1)
      $display("FAIL lu_release got C=%b F=%b exp C=0 F=1", bus.E_clear, bus.F_enable);
    else n_pass++;
    next_cycle(); #1;
    n_chk++;
    if (bus.stall_cnt !== 32'd2) $display("FAIL lu_cnt2 got=%0d exp=2", bus.stall_cnt);
    else n_pass++;
    // Tnew equal to Tuse is forwardable, not a stall
    idle_inputs();
    bus.D_rt = 5'd9; bus.D_Tuse_rt = 2'd1; bus.M_wa = 5'd9; bus.M_Tnew = 2'd1;
    #1;
    n_chk++;
    if (bus.E_clear !== 1'b0) $display("FAIL lu_equal_tnew got=%b exp=0", bus.E_clear);
    else n_pass++;
    bus.E_wa = 5'd9; bus.E_Tnew = 2'd3; bus.D_Tuse_rt = 2'd2;
    #1;
    n_chk++;
    if (bus.E_clear !== 1'b1) $display("FAIL lu_rt_e_stall got=%b exp=1", bus.E_clear);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_reg_zero();
    do_reset();
    bus.D_rs = 5'd0; bus.D_Tuse_rs = 2'd0; bus.E_wa = 5'd0; bus.E_Tnew = 2'd2;
    bus.M_wa = 5'd0; bus.M_Tnew = 2'd2;
    #1;
    n_chk++;
    if (bus.E_clear !== 1'b0) $display("FAIL rz_zero got=%b exp=0", bus.E_clear);
    else n_pass++;
    bus.D_rt = 5'd7; bus.D_Tuse_rt = 2'd3; bus.E_wa = 5'd7; bus.E_Tnew = 2'd2;
    #1;
    n_chk++;
    if (bus.E_clear !== 1'b0) $display("FAIL rz_no_use got=%b exp=0", bus.E_clear);
    else n_pass++;
    bus.D_Tuse_rt = 2'd1;
    #1;
    n_chk++;
    if (bus.E_clear !== 1'b1) $display("FAIL rz_rt_use got=%b exp=1", bus.E_clear);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_mult_mflo();
    do_reset();
    bus.E_start = 1'b1; bus.E_md_div = 1'b0; bus.D_is_md = 1'b1;
    #1;
    n_chk++;
    if (bus.E_clear !== 1'b1 || bus.md_busy !== 1'b0)
      $display("FAIL mm_start got C=%b busy=%b exp C=1 busy=0", bus.E_clear, bus.md_busy);
    else n_pass++;
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      bus.E_start = 1'b0;
      #1;
      n_chk++;
      if (bus.md_busy !== 1'b1 || bus.E_clear !== 1'b1)
        $display("FAIL mm_busy_c%0d got busy=%b C=%b exp 1 1", k, bus.md_busy, bus.E_clear);
      else n_pass++;
    end
    next_cycle(); #1;
    n_chk++;
    if (bus.md_busy !== 1'b0 || bus.E_clear !== 1'b0)
      $display("FAIL mm_done got busy=%b C=%b exp 0 0", bus.md_busy, bus.E_clear);
    else n_pass++;
    n_chk++;
    if (bus.stall_cnt !== 32'd6) $display("FAIL mm_cnt got=%0d exp=6", bus.stall_cnt);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_div();
    do_reset();
    bus.E_start = 1'b1; bus.E_md_div = 1'b1; bus.D_is_md = 1'b0;
    #1;
    n_chk++;
    if (bus.E_clear !== 1'b0) $display("FAIL dv_start got=%b exp=0", bus.E_clear);
    else n_pass++;
    for (int k = 1; k <= 10; k++) begin
      next_cycle();
      bus.E_start = 1'b0;
      if (k == 4) bus.D_is_md = 1'b1;
      #1;
      n_chk++;
      if (bus.md_busy !== 1'b1 || bus.E_clear !== (k >= 4))
        $display("FAIL dv_c%0d got busy=%b C=%b exp busy=1 C=%b",
                 k, bus.md_busy, bus.E_clear, (k >= 4));
      else n_pass++;
    end
    next_cycle(); #1;
    n_chk++;
    if (bus.md_busy !== 1'b0 || bus.E_clear !== 1'b0)
      $display("FAIL dv_done got busy=%b C=%b exp 0 0", bus.md_busy, bus.E_clear);
    else n_pass++;
    n_chk++;
    if (bus.stall_cnt !== 32'd7) $display("FAIL dv_cnt got=%0d exp=7", bus.stall_cnt);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_reset_mid_div();
    int busy_cycles;
    do_reset();
    bus.E_start = 1'b1; bus.E_md_div = 1'b1;
    next_cycle();
    bus.E_start = 1'b0; bus.D_is_md = 1'b1;  // stalls cycles 1 and 2
    next_cycle();
    next_cycle();
    reset = 1'b1;
    #1;
    n_chk++;
    if (bus.F_enable !== 1'b1 || bus.E_clear !== 1'b0)
      $display("FAIL rm_forced got F=%b C=%b exp F=1 C=0", bus.F_enable, bus.E_clear);
    else n_pass++;
    next_cycle();
    reset = 1'b0;
    #1;
    n_chk++;
    if (bus.md_busy !== 1'b0 || bus.stall_cnt !== 32'd0 || bus.F_enable !== 1'b1)
      $display("FAIL rm_after got busy=%b cnt=%0d F=%b exp 0 0 1",
               bus.md_busy, bus.stall_cnt, bus.F_enable);
    else n_pass++;
    bus.D_is_md = 1'b0;
    bus.E_start = 1'b1; bus.E_md_div = 1'b0;
    busy_cycles = 0;
    for (int k = 1; k <= 8; k++) begin
      next_cycle();
      // A div start while busy must be ignored
      bus.E_start = (k == 2);
      bus.E_md_div = 1'b1;
      #1;
      if (bus.md_busy === 1'b1) busy_cycles++;
    end
    n_chk++;
    if (busy_cycles != 5) $display("FAIL rm_mult_len got=%0d exp=5", busy_cycles);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    bus.D_rs = 5'd5; bus.D_Tuse_rs = 2'd0; bus.E_wa = 5'd5; bus.E_Tnew = 2'd2;
    for (int k = 1; k <= 20; k++) begin
      next_cycle();
      if (k == 15) begin
        #1;
        n_chk++;
        if (sbus.stall_cnt !== 4'd15) $display("FAIL sat_at15 got=%0d exp=15", sbus.stall_cnt);
        else n_pass++;
      end
    end
    idle_inputs();
    next_cycle(); #1;
    n_chk++;
    if (sbus.stall_cnt !== 4'd15) $display("FAIL sat_hold got=%0d exp=15", sbus.stall_cnt);
    else n_pass++;
    n_chk++;
    if (bus.stall_cnt !== 32'd20) $display("FAIL sat_wide got=%0d exp=20", bus.stall_cnt);
    else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_use();
    test_reg_zero();
    test_mult_mflo();
    test_div();
    test_reset_mid_div();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stall_ctrl.md
Name: stall_ctrl

Overview:
- Hazard and stall controller for the 5-stage pipeline.
- Drives the enable of the F and D pipeline registers and a bubble-insert (clear) for the D→E register.
- Decides stalls from Tuse/Tnew register-dependency comparison and from a multi-cycle multiply/divide busy counter it owns.
- Also keeps a saturating stall-cycle counter for performance debug.

Parameters:
- MULT_CYC, 5, busy cycles after a mult/multu enters E.
- DIV_CYC, 10, busy cycles after a div/divu enters E.
- CNT_W, 32, width of stall_cnt.

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  synchronous, active-high reset.
- D_rs  input  5  rs field of instruction in D.
- D_rt  input  5  rt field of instruction in D.
- D_Tuse_rs  input  2  cycles until D instr needs rs (3 = never uses).
- D_Tuse_rt  input  2  same for rt.
- D_is_md  input  1  D instr touches HI/LO or the MDU (mult/div/mfhi/mflo/mthi/mtlo).
- E_wa  input  5  destination register of instr in E (0 = none).
- E_Tnew  input  2  cycles until E result is available.
- M_wa  input  5  destination register of instr in M.
- M_Tnew  input  2  cycles until M result is available.
- E_start  input  1  instr in E is mult/multu/div/divu, valid this cycle.
- E_md_div  input  1  with E_start: 1 = div class, 0 = mult class.
- F_enable  output  1  enable for the F-stage PC/register.
- D_enable  output  1  enable for the D pipeline register.
- E_clear  output  1  load a bubble (all-zero) into the E register this edge.
- md_busy  output  1  MDU result not yet valid.
- stall_cnt  output  CNT_W  total stall cycles since reset, saturating.

Behaviour:
- Data hazard on rs (stall_rs) requires all of:
  - D_rs != 0.
  - Either (D_rs == E_wa && E_Tnew > D_Tuse_rs) or (D_rs == M_wa && M_Tnew > D_Tuse_rs).
  - Unsigned 2-bit compare.
- stall_rt is the same as stall_rs, using D_rt and D_Tuse_rt.
- A register-0 match never stalls, even if E_wa or M_wa is 0.
- Internal md_cnt, 4+ bits (wide enough for max(MULT_CYC, DIV_CYC)):
  - E_start && md_cnt == 0 → load DIV_CYC if E_md_div, else MULT_CYC.
  - Else if md_cnt != 0 → decrement by 1.
  - E_start while md_cnt != 0 is ignored (count unchanged); correct stalling makes this unreachable.
- md_busy = (md_cnt != 0), registered; it rises the cycle after E_start.
- stall_md = D_is_md && (md_busy || E_start). E_start is included so that back-to-back mult then mflo stalls in the start cycle.
- stall = stall_rs | stall_rt | stall_md, combinational, same cycle as inputs.
- F_enable = D_enable = !stall; E_clear = stall. E_clear takes priority over the E register enable in the parent.
- stall_cnt increments on every edge where stall = 1 and reset = 0; it holds at all-ones (saturates, no wrap).
- Reset (synchronous, active-high), on the edge with reset = 1:
  - md_cnt ← 0, stall_cnt ← 0.
  - While reset = 1: stall forced 0, so F_enable = D_enable = 1 and E_clear = 0.
  - Reset mid-mult/div aborts the count; md_busy = 0 the cycle after.
- Reset values: md_busy 0, stall_cnt 0, F_enable 1, D_enable 1, E_clear 0.
- Latency: stall outputs are 0-cycle (combinational); md_busy and stall_cnt are 1-cycle registered.
- No other state; the MDU datapath itself is external.

Test Plan:
- Load-use: D_rs=5, D_Tuse_rs=0, E_wa=5, E_Tnew=2 → stall=1, F_enable=0, E_clear=1. Next cycle E_wa=0, M_wa=5, M_Tnew=1 → still stall. Then M_Tnew=0 → stall=0; stall_cnt=2.
- Register zero and no-use: D_rs=0, E_wa=0, E_Tnew=2 → stall=0. D_rt=7, D_Tuse_rt=3, E_wa=7, E_Tnew=2 → stall=0.
- Mult then mflo: E_start=1, E_md_div=0, D_is_md=1 → stall that cycle. md_busy=1 for exactly 5 cycles after. Stall continues until md_busy drops, so 6 stall cycles total.
- Div timing: E_start=1, E_md_div=1, D_is_md=0 → no stall; md_busy high 10 cycles then 0. A D_is_md=1 arriving in cycle 4 stalls until md_busy=0.
- Reset mid-div: at cycle 3 of a div, assert reset one cycle → md_busy=0, stall_cnt=0, F_enable=1. A subsequent mult restarts the count at 5.
- Saturation (CNT_W=4 override): hold stall for 20 cycles → stall_cnt reaches 15 and stays 15.
